// File: rtl/vga_timing_sink.sv
// rtl/vga_timing_sink.sv - VGA raster generator with RGB return path aligned to sync/blank
// Optional colour-bar override is compiled in with VGA_TIMING_TESTPAT_EN.
module vga_timing_sink #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int PIPE_LAT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] in_R,
  input  logic [7:0] in_G,
  input  logic [7:0] in_B,
`ifdef VGA_TIMING_TESTPAT_EN
  input  logic       test_pat,
`endif
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Pipeline word: {bar index (test pattern only), act, vs, hs}
`ifdef VGA_TIMING_TESTPAT_EN
  localparam int PW = 6;
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
`else
  localparam int PW = 3;
`endif
  localparam logic [PW-1:0] PIPE_RST = PW'(3);

  logic [DW-1:0] r_div;
  logic [9:0]    r_h;
  logic [9:0]    r_v;
  logic          r_fs;
  logic          w_pix_en;
  logic          w_hs_raw;
  logic          w_vs_raw;
  logic          w_act_raw;
  logic [PW-1:0] w_raw;
  logic [PW-1:0] w_dly;
  logic [7:0]    w_r;
  logic [7:0]    w_g;
  logic [7:0]    w_b;
  logic          r_hs;
  logic          r_vs;
  logic          r_bn;
  logic [7:0]    r_r;
  logic [7:0]    r_g;
  logic [7:0]    r_b;

  assign w_pix_en = (r_div == DIV_MAX);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_div <= '0;
    end else if (w_pix_en) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DW'(1);
    end
  end

  // A divide-by-one pixel clock has no low half in div_cnt, so it toggles on its own.
  generate
    if (CLK_DIV == 1) begin : g_clk_tog
      logic r_vclk;
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          r_vclk <= 1'b1;
        end else begin
          r_vclk <= ~r_vclk;
        end
      end
      assign VGA_CLK = r_vclk;
    end else begin : g_clk_div
      assign VGA_CLK = (r_div < DIV_HALF);
    end
  endgenerate

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_h  <= '0;
      r_v  <= '0;
      r_fs <= 1'b0;
    end else begin
      r_fs <= w_pix_en && (r_h == H_MAX) && (r_v == V_MAX);
      if (w_pix_en) begin
        if (r_h == H_MAX) begin
          r_h <= '0;
          r_v <= (r_v == V_MAX) ? 10'd0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 10'd1;
        end
      end
    end
  end

  assign DrawX       = r_h;
  assign DrawY       = r_v;
  assign frame_start = r_fs;

  assign w_hs_raw  = !((r_h >= HS_BEG) && (r_h < HS_END));
  assign w_vs_raw  = !((r_v >= VS_BEG) && (r_v < VS_END));
  assign w_act_raw = (r_h < H_ACT) && (r_v < V_ACT);

`ifdef VGA_TIMING_TESTPAT_EN
  assign w_raw = {3'(r_h / BAR_W), w_act_raw, w_vs_raw, w_hs_raw};
`else
  assign w_raw = {w_act_raw, w_vs_raw, w_hs_raw};
`endif

  // Delay matches the colour stage latency; runs every Clk, independent of pix_en.
  generate
    if (PIPE_LAT == 0) begin : g_nodly
      assign w_dly = w_raw;
    end else begin : g_dly
      logic [PW-1:0] r_sr [PIPE_LAT];
      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          for (int i = 0; i < PIPE_LAT; i++) r_sr[i] <= PIPE_RST;
        end else begin
          r_sr[0] <= w_raw;
          for (int i = 1; i < PIPE_LAT; i++) r_sr[i] <= r_sr[i-1];
        end
      end
      assign w_dly = r_sr[PIPE_LAT-1];
    end
  endgenerate

  always_comb begin
    w_r = in_R;
    w_g = in_G;
    w_b = in_B;
`ifdef VGA_TIMING_TESTPAT_EN
    // Bar colour bits fall straight out of the bar index (white..black order).
    if (test_pat) begin
      w_r = {8{~w_dly[4]}};
      w_g = {8{~w_dly[5]}};
      w_b = {8{~w_dly[3]}};
    end
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hs <= 1'b1;
      r_vs <= 1'b1;
      r_bn <= 1'b0;
      r_r  <= '0;
      r_g  <= '0;
      r_b  <= '0;
    end else begin
      r_hs <= w_dly[0];
      r_vs <= w_dly[1];
      r_bn <= w_dly[2];
      r_r  <= w_dly[2] ? w_r : 8'h00;
      r_g  <= w_dly[2] ? w_g : 8'h00;
      r_b  <= w_dly[2] ? w_b : 8'h00;
    end
  end

  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_bn;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_r;
  assign VGA_G       = r_g;
  assign VGA_B       = r_b;

endmodule

// File: tb/tb_vga_timing_sink.sv
// tb/tb_vga_timing_sink.sv - scoreboard bench for vga_timing_sink on a reduced raster
module tb_vga_timing_sink;
  localparam int HA = 160, HF = 8, HS = 16, HB = 16;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int CD = 2, PL = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT * CD;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic       vclk;
    logic       hs;
    logic       vs;
    logic       bn;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] in_R = 8'h00, in_G = 8'h00, in_B = 8'h00;
  logic       tp = 1'b0;
  logic [9:0] DrawX, DrawY;
  logic       frame_start, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  logic [7:0] lut [256];
  exp_t       sb_q [$];
  int         k = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  vga_timing_sink #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .PIPE_LAT(PL)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .in_R(in_R), .in_G(in_G), .in_B(in_B),
`ifdef VGA_TIMING_TESTPAT_EN
    .test_pat(tp),
`endif
    .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
    .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (k=%0d t=%0t)", nm, got, want, k, $time);
    end
  endtask

  function automatic logic [23:0] bar_rgb(input int bar);
    case (bar)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Expected DUT state after the k-th rising edge since reset release.
  function automatic exp_t model(input int kk, input logic tpat);
    exp_t e;
    int p, j, pp, px, py;
    logic act;
    logic [23:0] rgb;
    p      = kk / CD;
    e.x    = 10'(p % HT);
    e.y    = 10'((p / HT) % VT);
    e.fs   = (kk >= 1) && (p % (HT * VT) == 0) && (((kk - 1) / CD) != p);
    e.vclk = (kk % CD) < (CD / 2);
    j = kk - PL - 1;
    if (j < 0) begin
      e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0;
      e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
    end else begin
      pp  = j / CD;
      px  = pp % HT;
      py  = (pp / HT) % VT;
      act = (px < HA) && (py < VA);
      e.hs = !((px >= HA + HF) && (px < HA + HF + HS));
      e.vs = !((py >= VA + VF) && (py < VA + VF + VS));
      e.bn = act;
      if (tpat) rgb = bar_rgb(px / (HA / 8));
      else      rgb = {8'(px), 8'(py), lut[8'(px) ^ 8'(py)]};
      if (!act) rgb = 24'h000000;
      {e.r, e.g, e.b} = rgb;
    end
    return e;
  endfunction

  // Colour stage: returns a colour derived from the pixel shown PL Clk earlier.
  logic [19:0] d1 = '0, d2 = '0, d3 = '0;
  initial forever begin
    @(posedge Clk);
    #1;
    d3 = d2; d2 = d1; d1 = {DrawY, DrawX};
    in_R = d3[7:0];
    in_G = d3[17:10];
    in_B = lut[d3[7:0] ^ d3[17:10]];
  end

  initial forever begin
    @(posedge Clk);
    if (Reset === 1'b0) begin
      k++;
      sb_q.push_back(model(k, tp));
    end
  end

  initial forever begin
    exp_t e;
    @(negedge Clk);
    if (Reset === 1'b0 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("DrawX", 32'(DrawX), 32'(e.x));
      chk("DrawY", 32'(DrawY), 32'(e.y));
      chk("frame_start", 32'(frame_start), 32'(e.fs));
      chk("VGA_CLK", 32'(VGA_CLK), 32'(e.vclk));
      chk("VGA_HS", 32'(VGA_HS), 32'(e.hs));
      chk("VGA_VS", 32'(VGA_VS), 32'(e.vs));
      chk("VGA_BLANK_N", 32'(VGA_BLANK_N), 32'(e.bn));
      chk("VGA_SYNC_N", 32'(VGA_SYNC_N), 32'd0);
      chk("VGA_R", 32'(VGA_R), 32'(e.r));
      chk("VGA_G", 32'(VGA_G), 32'(e.g));
      chk("VGA_B", 32'(VGA_B), 32'(e.b));
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_DrawX"}, 32'(DrawX), 32'd0);
    chk({tag, "_DrawY"}, 32'(DrawY), 32'd0);
    chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, "_VGA_CLK"}, 32'(VGA_CLK), 32'd1);
    chk({tag, "_VGA_HS"}, 32'(VGA_HS), 32'd1);
    chk({tag, "_VGA_VS"}, 32'(VGA_VS), 32'd1);
    chk({tag, "_BLANK_N"}, 32'(VGA_BLANK_N), 32'd0);
    chk({tag, "_RGB"}, 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    #1;
    check_reset_state(tag);
    sb_q.delete();
    k = 0;
    run(3);
    Reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) lut[i] = 8'($urandom);
    Reset = 1'b1;
    tp    = 1'b0;
    run(4);
    check_reset_state("init");
    k = 0;
    Reset = 1'b0;

    run(2 * FRAME + 37);
    for (int i = 0; i < 3; i++) begin
      run($urandom_range(50, 3000));
      do_reset("midline");
    end
    run(FRAME + 100);

`ifdef VGA_TIMING_TESTPAT_EN
    tp = 1'b1;
    run(FRAME + 10);
    repeat (2000) begin
      tp = 1'($urandom_range(0, 1));
      run(1);
    end
    do_reset("tp_reset");
    tp = 1'b0;
    run(FRAME);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_sink.md
Name: vga_timing_sink

Overview:
- Generates the raster that drives the per-pixel color stage, and receives that stage's RGB result.
- Produces pixel coordinates DrawX/DrawY, the VGA pixel clock, sync, blank and a frame_start tick.
- Takes the color stage's RGB back after its ROM/palette pipeline latency, and drives the VGA pins with sync, blank and RGB all aligned.
- Sits between the color mapper and the board VGA DAC; frame_start paces the game-object update logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, Clk cycles per pixel (pixel enable period), >=1
PIPE_LAT, 2, Clk cycles from DrawX/DrawY change to valid in_R/G/B, 0..7

Ports:
Clk  in  1  system clock (50 MHz)
Reset  in  1  asynchronous, active-high reset
in_R  in  8  red from color stage, pixel at DrawX/DrawY PIPE_LAT Clk earlier
in_G  in  8  green, same timing as in_R
in_B  in  8  blue, same timing as in_R
DrawX  out  10  current horizontal count, 0..H_TOTAL-1
DrawY  out  10  current vertical count, 0..V_TOTAL-1
frame_start  out  1  one-Clk pulse when the counters wrap to (0,0)
VGA_CLK  out  1  pixel clock, high for the first half of each pixel period
VGA_HS  out  1  hsync, active low, aligned with RGB
VGA_VS  out  1  vsync, active low, aligned with RGB
VGA_BLANK_N  out  1  low outside the active area, aligned with RGB
VGA_SYNC_N  out  1  constant 0
VGA_R  out  8  red to DAC
VGA_G  out  8  green to DAC
VGA_B  out  8  blue to DAC

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).

Divider:
- div_cnt runs 0..CLK_DIV-1 on Clk.
- pix_en=1 when div_cnt==CLK_DIV-1.
- VGA_CLK=1 while div_cnt < CLK_DIV/2 (with CLK_DIV=1, VGA_CLK=Clk-rate toggle register).

Counters:
- On pix_en, h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
- v_cnt wraps to 0 after V_TOTAL-1.
- DrawX=h_cnt and DrawY=v_cnt, registered, stable for CLK_DIV Clk per pixel.
- frame_start=1 for exactly the Clk in which (h,v) goes from (H_TOTAL-1, V_TOTAL-1) to (0,0).

Raw timing (undelayed):
- hs_raw=0 iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (656..751).
- vs_raw=0 iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- act_raw=1 iff h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.

Alignment pipeline:
- hs_raw, vs_raw and act_raw pass through a PIPE_LAT-stage shift register clocked every Clk, not gated by pix_en.
- One output register stage then drives all pins:
  - VGA_HS and VGA_VS take the delayed syncs.
  - VGA_BLANK_N takes delayed act.
  - VGA_R/G/B take in_R/G/B when delayed act=1, else 0x00.
- Total latency: pin outputs reflect the DrawX/DrawY value from PIPE_LAT+1 Clk earlier.

Reset (async, any time, including mid-line):
- div_cnt, h_cnt, v_cnt, DrawX, DrawY = 0.
- frame_start = 0; VGA_CLK = 1.
- VGA_HS = VGA_VS = 1 (inactive); VGA_BLANK_N = 0; VGA_R/G/B = 0.
- All delay-stage contents are set to sync=1, act=0.
- First pix_en after release occurs CLK_DIV Clk after the first rising edge.
- No frame_start is generated for the reset-induced jump to (0,0).

Boundaries:
- Counters never exceed H_TOTAL-1 / V_TOTAL-1.
- PIPE_LAT=0 means no delay stages; only the output register remains.

Optional Feature:
- Macro: VGA_TIMING_TESTPAT_EN.
- Defined:
  - Adds input port test_pat (1 bit).
  - When test_pat=1, VGA_R/G/B ignore in_R/G/B and show 8 vertical bars of H_ACTIVE/8 (80) pixels each.
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Bars are computed from h_cnt delayed through the same pipeline, so they share the RGB alignment.
  - Blanking still forces 0.
  - test_pat is sampled every Clk.
- Undefined: the port is absent and RGB always comes from in_R/G/B.

Test Plan:
- Reset asserted mid-line at h=300,v=100 -> same Clk: DrawX=0, DrawY=0, VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0, RGB=0. After release: DrawX reaches 1 after 2 Clk, and no frame_start pulse.
- Free run CLK_DIV=2 -> VGA_HS period 1600 Clk with a 192-Clk low pulse. Low starts when DrawX=656 plus 3 Clk (PIPE_LAT+1).
- Free run -> VGA_VS low for 2 lines (3200 Clk) starting at line 490. frame_start period = 840000 Clk, one Clk wide.
- in_R=in_G=in_B=FF constant -> VGA_R=FF only while VGA_BLANK_N=1; 0x00 at pixels 640..799 and lines 480..524. BLANK_N high for exactly 1280 Clk per active line.
- Model color stage as in_R = DrawX[7:0] delayed 2 Clk -> VGA_R equals the pixel's X and never mixes adjacent pixels. VGA_R=0x7F observed exactly while the pixel with DrawX=127 is at the pins.
- With VGA_TIMING_TESTPAT_EN, test_pat=1 -> pixels 0..79 = FFFFFF, 80..159 = FFFF00, ... 560..639 = 000000, and blanking still 0. Setting test_pat=0 restores in_RGB passthrough.
